// File: rtl/bundle_sequencer.sv
// bundle_sequencer
// ----------------
// Initiator side of the bundler handshake in the sample-encoding path. For
// each hypervector dimension d (0..DIM-1) it reads the pre-bound feature bits
// from item memory, presents them to the bundler, waits for the bundler to
// finish, and stores the thresholded result in hv_out[d]. When all DIM
// dimensions are done, it pulses hv_valid for one cycle.
//
// Per-dimension sequence:
//   FETCH  -> LOAD  -> BUNDLE (k cycles, k >= 1) -> GAP
// This takes 3 + k cycles. A sample takes DIM*(3+k) + 1 cycles from the
// start_req cycle to the hv_valid cycle.
//
// Ports
//   clk             in   system clock; all state changes on the rising edge
//   rst             in   asynchronous reset, active-high
//   en              in   global enable; low freezes all state
//   start_req       in   request to encode one sample (honoured only in IDLE)
//   mem_addr        out  item-memory read address (current dimension)
//   mem_rd          out  item-memory read strobe (one cycle per dimension)
//   mem_rdata       in   item-memory data, valid one cycle after mem_rd
//   bits_to_bundle  out  registered feature bits presented to the bundler
//   start_bundling  out  bundler request; held until bundling_done
//   bundling_done   in   bundler completion (level, held by the bundler)
//   thresholded_bit in   bundler result, valid while bundling_done=1
//   hv_out          out  encoded hypervector, bit d = result of dimension d
//   hv_valid        out  one-cycle pulse when hv_out is complete
//   busy            out  high in every state except IDLE
module bundle_sequencer #(
    parameter int FEATURE_COUNT = 40,
    parameter int DIM           = 256,
    parameter int ADDR_W        = $clog2(DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd,
    input  logic [FEATURE_COUNT-1:0] mem_rdata,
    output logic [FEATURE_COUNT-1:0] bits_to_bundle,
    output logic                     start_bundling,
    input  logic                     bundling_done,
    input  logic                     thresholded_bit,
    output logic [DIM-1:0]           hv_out,
    output logic                     hv_valid,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_BUNDLE = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_DIM = ADDR_W'(DIM - 1);

    state_t                   state_reg, state_next;
    logic [ADDR_W-1:0]        dim_cnt_reg, dim_cnt_next;
    logic [FEATURE_COUNT-1:0] bits_reg, bits_next;
    logic [DIM-1:0]           hv_reg, hv_next;

    // State register. The asynchronous reset aborts any transaction at once,
    // so start_bundling (decoded from state) drops in the same cycle as rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            dim_cnt_reg <= '0;
            bits_reg    <= '0;
            hv_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            dim_cnt_reg <= dim_cnt_next;
            bits_reg    <= bits_next;
            hv_reg      <= hv_next;
        end
    end

    // Next-state logic. With en low, every "next" value equals its current
    // value, so nothing advances. This includes capturing bundling_done, so
    // the bundler must keep done high until it sees start_bundling fall.
    always_comb begin
        state_next   = state_reg;
        dim_cnt_next = dim_cnt_reg;
        bits_next    = bits_reg;
        hv_next      = hv_reg;

        if (en) begin
            case (state_reg)
                S_IDLE: begin
                    // hv_out is intentionally not cleared. It is overwritten
                    // bit by bit as the new sample progresses.
                    if (start_req) begin
                        dim_cnt_next = '0;
                        state_next   = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_next = S_LOAD;
                end
                S_LOAD: begin
                    // Read data arrives one cycle after the FETCH strobe.
                    bits_next  = mem_rdata;
                    state_next = S_BUNDLE;
                end
                S_BUNDLE: begin
                    if (bundling_done) begin
                        hv_next[dim_cnt_reg] = thresholded_bit;
                        state_next           = S_GAP;
                    end
                end
                S_GAP: begin
                    // Mandatory return-to-zero cycle on start_bundling. The
                    // terminal count is checked here, so dim_cnt never wraps
                    // mid-sample.
                    if (dim_cnt_reg == LAST_DIM) begin
                        state_next = S_DONE;
                    end else begin
                        dim_cnt_next = dim_cnt_reg + ADDR_W'(1);
                        state_next   = S_FETCH;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Output decode. The strobes are gated by en so a frozen FETCH or DONE
    // state does not repeat a read or a valid pulse. start_bundling is a
    // pure state decode, so it holds its level while en is low.
    always_comb begin
        mem_addr       = dim_cnt_reg;
        mem_rd         = en && (state_reg == S_FETCH);
        bits_to_bundle = bits_reg;
        start_bundling = (state_reg == S_BUNDLE);
        hv_out         = hv_reg;
        hv_valid       = en && (state_reg == S_DONE);
        busy           = (state_reg != S_IDLE);
    end

endmodule

// File: tb/tb_bundle_sequencer.sv
// Directed testbench for bundle_sequencer with DIM=4 and FEATURE_COUNT=40.
// The bench models the item memory (one-cycle read latency) and a bundler.
// The bundler raises done after wait_k BUNDLE cycles, keeps done high while
// start_bundling stays high, and returns the majority (>20 of 40 bits set)
// of bits_to_bundle.
//
// Hand-computed majorities for the first memory image (popcount -> bit):
//   addr0 F5AC39B72F: 25 -> 1
//   addr1 F4AC39B821: 19 -> 0
//   addr2 0000000000:  0 -> 0
//   addr3 FFFFFFFFFF: 40 -> 1
//   so hv_out = 4'b1001.
// Second image {0, all-ones, all-ones, 0} gives hv_out = 4'b0110.
module tb_bundle_sequencer;
    localparam int FC = 40;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          start_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [FC-1:0] mem_rdata = '0;
    logic [FC-1:0] bits_to_bundle;
    logic          start_bundling;
    logic          bundling_done;
    logic          thresholded_bit;
    logic [D-1:0]  hv_out;
    logic          hv_valid;
    logic          busy;

    bundle_sequencer #(.FEATURE_COUNT(FC), .DIM(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .start_req(start_req),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .bits_to_bundle(bits_to_bundle), .start_bundling(start_bundling),
        .bundling_done(bundling_done), .thresholded_bit(thresholded_bit),
        .hv_out(hv_out), .hv_valid(hv_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Item memory with a one-cycle read latency.
    logic [FC-1:0] mem [0:D-1];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // Bundler model.
    int   bcnt = 0;
    int   wait_k = 3;
    logic spur_done = 1'b0;
    always @(posedge clk) bcnt <= start_bundling ? bcnt + 1 : 0;
    assign bundling_done   = (start_bundling && (bcnt >= wait_k - 1)) || spur_done;
    assign thresholded_bit = ($countones(bits_to_bundle) > 20);

    // Handshake monitor. It samples at negedge and counts protocol violations.
    int        hv_cnt = 0;
    int        viol = 0;
    int        low_run = 0;
    bit        seen_fall = 0;
    logic      prev_rd = 0;
    logic      prev_sb = 0;
    logic [FC-1:0] prev_bits = '0;
    int        addr_log[$];

    always @(negedge clk) begin
        if (hv_valid) hv_cnt++;
        if (mem_rd) begin
            addr_log.push_back(int'(mem_addr));
            if (start_bundling) viol++;
        end
        if (prev_rd && start_bundling) viol++;
        if (start_bundling && prev_sb && bits_to_bundle !== prev_bits) viol++;
        if (start_bundling && bits_to_bundle !== mem[mem_addr]) viol++;
        if (start_bundling && !prev_sb && seen_fall && low_run != 3) viol++;
        if (!start_bundling && prev_sb) begin
            seen_fall = 1;
            low_run   = 1;
        end else if (!start_bundling) begin
            low_run++;
        end
        if (hv_valid || !busy) seen_fall = 0;
        prev_rd   = mem_rd;
        prev_sb   = start_bundling;
        prev_bits = bits_to_bundle;
    end

    int passed = 0;
    int total  = 0;
    int t0 = 0;
    int tv = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        hv_cnt = 0;
        viol = 0;
        addr_log.delete();
    endtask

    task automatic start_sample();
        @(posedge clk); #1;
        start_req = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start_req = 1'b0;
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (!hv_valid && i < 300) begin
            smp();
            i++;
        end
        check("hv_valid_seen", 64'(hv_valid), 64'd1);
        tv = cyc;
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_rd_count"}, 64'(addr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size())
                check({tag, "_rd_addr"}, 64'(addr_log[i]), 64'(i));
        end
    endtask

    task automatic finish_sample(input string tag, input int lat, input logic [D-1:0] hv_exp);
        check({tag, "_latency"}, 64'(tv - t0), 64'(lat));
        check({tag, "_hv_out"}, 64'(hv_out), 64'(hv_exp));
        smp();
        check({tag, "_hv_valid_one_cycle"}, 64'(hv_valid), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_hv_cnt"}, 64'(hv_cnt), 64'd1);
        check({tag, "_handshake_viol"}, 64'(viol), 64'd0);
        check_addrs(tag);
        $display("sample %s: latency=%0d hv_out=%b", tag, tv - t0, hv_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; start_req = 1'b0;
        mem[0] = 40'hF5AC39B72F; mem[1] = 40'hF4AC39B821;
        mem[2] = 40'h0000000000; mem[3] = 40'hFFFFFFFFFF;

        // Reset state.
        smp(); smp();
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_bits", 64'(bits_to_bundle), 64'd0);
        check("rst_start_bundling", 64'(start_bundling), 64'd0);
        check("rst_hv_out", 64'(hv_out), 64'd0);
        check("rst_hv_valid", 64'(hv_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Scenario 1/2: basic sample with a 3-cycle bundler.
        clear_mon();
        start_sample();
        check("s1_busy", 64'(busy), 64'd1);
        wait_valid();
        finish_sample("s1", 25, 4'b1001);

        // Scenario 3: en low for 5 cycles in the done cycle of dimension 2.
        clear_mon();
        start_sample();
        for (int i = 0; i < 300 && !(mem_addr == 2 && start_bundling && bundling_done); i++) smp();
        check("s3_reach_dim2_done", 64'(start_bundling && bundling_done && mem_addr == 2), 64'd1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("s3_frozen_sb", 64'(start_bundling), 64'd1);
            check("s3_frozen_addr", 64'(mem_addr), 64'd2);
            check("s3_frozen_rd", 64'(mem_rd), 64'd0);
        end
        @(posedge clk); #1; en = 1'b1;
        wait_valid();
        finish_sample("s3", 30, 4'b1001);

        // Scenario 4: start_req re-pulsed mid-sample; spurious done in FETCH.
        clear_mon();
        start_sample();
        for (int i = 0; i < 300 && mem_addr != 1; i++) smp();
        @(posedge clk); #1; start_req = 1'b1;
        @(posedge clk); #1; start_req = 1'b0;
        for (int i = 0; i < 300 && !(mem_rd && mem_addr == 2); i++) smp();
        check("s4_in_fetch_dim2", 64'(mem_rd), 64'd1);
        spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        wait_valid();
        finish_sample("s4", 25, 4'b1001);

        // Scenario 5: reset during BUNDLE of dimension 2, then a clean restart.
        clear_mon();
        start_sample();
        for (int i = 0; i < 300 && !(mem_addr == 2 && start_bundling); i++) smp();
        rst = 1'b1;
        #1;
        check("s5_rst_sb", 64'(start_bundling), 64'd0);
        check("s5_rst_busy", 64'(busy), 64'd0);
        check("s5_rst_hv_out", 64'(hv_out), 64'd0);
        check("s5_rst_addr", 64'(mem_addr), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        smp();
        clear_mon();
        start_sample();
        wait_valid();
        finish_sample("s5", 25, 4'b1001);

        // Scenario 6: zero-wait bundler and a new memory image.
        wait_k = 1;
        mem[0] = 40'h0; mem[1] = 40'hFFFFFFFFFF; mem[2] = 40'hFFFFFFFFFF; mem[3] = 40'h0;
        clear_mon();
        start_sample();
        check("s6_hv_not_cleared", 64'(hv_out), 64'(4'b1001));
        wait_valid();
        finish_sample("s6", 17, 4'b0110);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
